parsing_feeder: RTL and testbench

- Parametrised successor of the layer-00 parser. Reads a feature map from NUM_CH read-port BRAMs that share one address, one BRAM per channel.
- Walks the zero-padded image in raster order with a runtime-selectable pad width.
- Emits one pixel per channel per beat on a valid/ready stream with full backpressure.
- Sits between the BRAM bank and the conv PE array.

---
 rtl/parsing_pkg.sv | 39 +++
 rtl/parsing_skid_fifo.sv | 41 ++++
 rtl/parsing_feeder.sv | 178 +++++++++++++++++
 tb/tb_parsing_feeder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/parsing_pkg.sv
// rtl/parsing_pkg.sv - shared state encoding, geometry helpers and sideband widths for the parsing feeder
package parsing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feederState_t;

    // Pad width input is 2 bits; anything above this is clamped down to it
    localparam int               PAD_W   = 2;
    localparam logic [PAD_W-1:0] PAD_MAX = 2'd2;

    // Sideband entry fields carried alongside each BRAM read
    localparam int SB_PAD_W  = 1;
    localparam int SB_LAST_W = 1;

    function automatic int calcPpw(input int dw, input int pixW);
        return dw / pixW;
    endfunction

    function automatic int calcLog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

    // Lane index needs at least one bit even when a word holds a single pixel
    function automatic int laneWidth(input int ppw);
        int l;
        l = calcLog2(ppw);
        return (l < 1) ? 1 : l;
    endfunction

endpackage

// File: rtl/parsing_skid_fifo.sv
// rtl/parsing_skid_fifo.sv - two-entry valid/ready output buffer
module parsing_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wrData,
    input  logic             wrEn,
    output logic [WIDTH-1:0] rdData,
    output logic             rdValid,
    input  logic             rdEn,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             wrPtr;
    logic             rdPtr;
    logic             doPop;

    assign doPop   = rdEn && rdValid;
    assign rdValid = (count != 2'd0);
    assign rdData  = mem[rdPtr];

    // Storage and pointers; the writer never pushes into a full buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wrEn) begin
                mem[wrPtr] <= wrData;
                wrPtr      <= ~wrPtr;
            end
            if (doPop) rdPtr <= ~rdPtr;
            count <= count + 2'(wrEn) - 2'(doPop);
        end
    end

endmodule

// File: rtl/parsing_feeder.sv
// rtl/parsing_feeder.sv - padded raster walker feeding BRAM pixels to the PE array (optional PARSING_FEEDER_STAT_EN beat counter)
module parsing_feeder
    import parsing_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int DW     = 128,
    parameter int AW     = 9,
    parameter int PIX_W  = 8,
    parameter int DIM_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [DIM_W-1:0]        i_width,
    input  logic [DIM_W-1:0]        i_height,
    input  logic [1:0]              i_pad,
    output logic [NUM_CH-1:0]       o_cs,
    output logic [AW-1:0]           o_addr,
    input  logic [NUM_CH*DW-1:0]    i_rdata,
    output logic [NUM_CH*PIX_W-1:0] o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_last,
    output logic                    o_busy,
    output logic                    o_done
`ifdef PARSING_FEEDER_STAT_EN
    ,
    output logic [2*DIM_W+1:0]      o_beat_cnt
`endif
);
    localparam int PPW      = calcPpw(DW, PIX_W);
    localparam int LOG2_PPW = calcLog2(PPW);
    localparam int LANE_W   = laneWidth(PPW);
    localparam int CW       = DIM_W + 1;
    localparam int PW       = 2 * DIM_W + 2;
    localparam int OW       = NUM_CH * PIX_W;
    localparam int FW       = OW + SB_LAST_W;
    localparam logic [DIM_W-1:0] LANE_MASK = DIM_W'(PPW - 1);

    feederState_t          state, stateNext;
    logic [DIM_W-1:0]      wQ, hQ;
    logic [PAD_W-1:0]      pQ;
    logic [CW-1:0]         row, col, rowsTot, colsTot, padExt;
    logic [DIM_W-1:0]      xPos, yPos;
    logic [DIM_W:0]        wordsPerRow;
    logic                  interior, lastPos, credit, issue, issueRd;
    logic [2:0]            occupancy;
    logic                  sbValid;
    logic [SB_PAD_W-1:0]   sbPad;
    logic [SB_LAST_W-1:0]  sbLast;
    logic [LANE_W-1:0]     sbLane;
    logic [OW-1:0]         pixels;
    logic [FW-1:0]         fifoHead;
    logic                  fifoValid, popNow;
    logic [1:0]            fifoCount;

    assign padExt   = CW'({pQ, 1'b0});
    assign rowsTot  = CW'(hQ) + padExt;
    assign colsTot  = CW'(wQ) + padExt;
    assign interior = (row >= CW'(pQ)) && (row < CW'(hQ) + CW'(pQ)) &&
                      (col >= CW'(pQ)) && (col < CW'(wQ) + CW'(pQ));
    assign xPos     = DIM_W'(col - CW'(pQ));
    assign yPos     = DIM_W'(row - CW'(pQ));
    assign lastPos  = (row == rowsTot - CW'(1)) && (col == colsTot - CW'(1));

    // ceil(W/PPW) words per image row; address wraps at the BRAM depth
    assign wordsPerRow = ({1'b0, wQ} + (DIM_W + 1)'(PPW - 1)) >> LOG2_PPW;

    // Beats already buffered or still in the BRAM pipe, net of a pop this cycle
    assign popNow    = fifoValid && i_ready;
    assign occupancy = {1'b0, fifoCount} + {2'b0, sbValid} - {2'b0, popNow};
    assign credit    = (occupancy < 3'd2);
    assign issue     = (state == ST_RUN) && credit;
    assign issueRd   = issue && interior;

    assign o_cs   = {NUM_CH{issueRd}};
    assign o_addr = issueRd ? AW'(PW'(yPos) * PW'(wordsPerRow) + PW'(xPos >> LOG2_PPW)) : '0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= stateNext;
    end

    // Next-state logic; empty frames skip straight to DONE
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_width == '0 || i_height == '0) stateNext = ST_DONE;
                    else                                 stateNext = ST_RUN;
                end
            end
            ST_RUN:   if (issue && lastPos) stateNext = ST_DRAIN;
            ST_DRAIN: if (popNow && fifoHead[FW-1]) stateNext = ST_DONE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    // Latch frame geometry on start, then walk the padded raster one issue at a time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wQ  <= '0;
            hQ  <= '0;
            pQ  <= '0;
            row <= '0;
            col <= '0;
        end else if (state == ST_IDLE && i_start) begin
            wQ  <= i_width;
            hQ  <= i_height;
            pQ  <= (i_pad > PAD_MAX) ? PAD_MAX : i_pad;
            row <= '0;
            col <= '0;
        end else if (issue) begin
            if (col == colsTot - CW'(1)) begin
                col <= '0;
                row <= row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Sideband travels one cycle behind the read to meet the BRAM data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbValid <= 1'b0;
            sbPad   <= '0;
            sbLast  <= '0;
            sbLane  <= '0;
        end else begin
            sbValid <= issue;
            sbPad   <= SB_PAD_W'(!interior);
            sbLast  <= SB_LAST_W'(lastPos);
            sbLane  <= LANE_W'(xPos & LANE_MASK);
        end
    end

    // Pick the lane out of each channel word, or zero on padding
    always_comb begin
        pixels = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sbPad == '0) pixels[k*PIX_W +: PIX_W] = i_rdata[k*DW + int'(sbLane)*PIX_W +: PIX_W];
        end
    end

    parsing_skid_fifo #(.WIDTH(FW)) skidFifo (
        .clk     (clk),
        .rst     (rst),
        .wrData  ({sbLast, pixels}),
        .wrEn    (sbValid),
        .rdData  (fifoHead),
        .rdValid (fifoValid),
        .rdEn    (i_ready),
        .count   (fifoCount)
    );

    assign o_valid = fifoValid;
    assign o_data  = fifoHead[OW-1:0];
    assign o_last  = fifoValid && fifoHead[FW-1];
    assign o_busy  = (state != ST_IDLE);
    assign o_done  = (state == ST_DONE);

`ifdef PARSING_FEEDER_STAT_EN
    logic [2*DIM_W+1:0] beatCnt;

    // Accepted-beat counter, restarted by each accepted start and held afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               beatCnt <= '0;
        else if (state == ST_IDLE && i_start)  beatCnt <= '0;
        else if (popNow)                       beatCnt <= beatCnt + 1'b1;
    end

    assign o_beat_cnt = beatCnt;
`endif

endmodule

// File: tb/tb_parsing_feeder.sv
// tb/tb_parsing_feeder.sv - directed bench for parsing_feeder
module tb_parsing_feeder;
    localparam int NUM_CH = 16;
    localparam int DW     = 128;
    localparam int AW     = 9;
    localparam int PIX_W  = 8;
    localparam int DIM_W  = 10;
    localparam int PPW    = DW / PIX_W;
    localparam int OW     = NUM_CH * PIX_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_start;
    logic [DIM_W-1:0]     i_width, i_height;
    logic [1:0]           i_pad;
    logic [NUM_CH-1:0]    o_cs;
    logic [AW-1:0]        o_addr;
    logic [NUM_CH*DW-1:0] i_rdata;
    logic [OW-1:0]        o_data;
    logic                 o_valid, i_ready, o_last, o_busy, o_done;
`ifdef PARSING_FEEDER_STAT_EN
    logic [2*DIM_W+1:0]   o_beat_cnt;
    logic [2*DIM_W+1:0]   cntAtStart;
`endif

    int nChecks = 0;
    int nPass   = 0;

    logic [DW-1:0] bram [NUM_CH][1 << AW];
    logic [OW:0]   gotQ[$];
    int            firstValidIter, doneIter, lastAcceptIter, doneCount, busyCount, csCount, csBad;
    logic [AW-1:0] addr17;

    always #5 clk = ~clk;

    parsing_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_width  (i_width),
        .i_height (i_height),
        .i_pad    (i_pad),
        .o_cs     (o_cs),
        .o_addr   (o_addr),
        .i_rdata  (i_rdata),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_last   (o_last),
        .o_busy   (o_busy),
        .o_done   (o_done)
`ifdef PARSING_FEEDER_STAT_EN
        ,
        .o_beat_cnt (o_beat_cnt)
`endif
    );

    // BRAM bank model: one-cycle read latency, output held when not selected
    always @(posedge clk) begin
        if (o_cs[0]) begin
            for (int k = 0; k < NUM_CH; k++) i_rdata[k*DW +: DW] <= bram[k][o_addr];
        end
    end

    task automatic checkEq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] pix(input int k, input int y, input int x);
        return 8'(16 * k + 4 * y + x);
    endfunction

    task automatic fillBram(input int w, input int h);
        int wpr;
        int a;
        wpr = (w + PPW - 1) / PPW;
        for (int k = 0; k < NUM_CH; k++)
            for (int i = 0; i < (1 << AW); i++) bram[k][i] = {PPW{8'hA5}};
        for (int k = 0; k < NUM_CH; k++)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++) begin
                    a = (y * wpr + x / PPW) % (1 << AW);
                    bram[k][a][(x % PPW)*PIX_W +: PIX_W] = pix(k, y, x);
                end
    endtask

    // Drive one frame; rstAt >= 0 asserts rst once that many beats have been taken
    task automatic runFrame(input int w, input int h, input int p, input bit randReady, input int rstAt);
        bit          finished;
        bit          aborted;
        bit          prevStall;
        logic [OW:0] prevBeat;
        gotQ.delete();
        firstValidIter = -1; doneIter = -1; lastAcceptIter = -1;
        doneCount = 0; busyCount = 0; csCount = 0; csBad = 0; addr17 = '1;
        finished = 0; aborted = 0; prevStall = 0; prevBeat = '0;
        @(negedge clk);
        i_width = DIM_W'(w); i_height = DIM_W'(h); i_pad = 2'(p); i_start = 1'b1;
        i_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int iter = 0; iter < 3000 && !finished; iter++) begin
            if (iter > 0) begin
                @(negedge clk);
                i_start = 1'b0;
                i_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            end
`ifdef PARSING_FEEDER_STAT_EN
            if (iter == 1) cntAtStart = o_beat_cnt;
`endif
            if (prevStall) begin
                checkEq("stall_valid", 160'(o_valid), 160'(1));
                checkEq("stall_hold", 160'({o_last, o_data}), 160'(prevBeat));
            end
            prevStall = o_valid && !i_ready;
            prevBeat  = {o_last, o_data};
            if (o_busy) busyCount++;
            if (o_cs != '0) begin
                csCount++;
                if (o_cs != '1) csBad++;
                if (csCount == 18) addr17 = o_addr;
            end
            if (o_valid && firstValidIter < 0) firstValidIter = iter;
            if (o_valid && i_ready) begin
                gotQ.push_back({o_last, o_data});
                lastAcceptIter = iter;
            end
            if (o_done) begin
                doneCount++;
                if (doneIter < 0) doneIter = iter;
                finished = 1;
            end
            if (rstAt >= 0 && gotQ.size() == rstAt) begin
                rst = 1'b1;
                #1;
                checkEq("rst_async_outs", 160'({o_cs, o_addr, o_data, o_valid, o_last, o_busy, o_done}), 160'(0));
                @(posedge clk);
                #1;
                checkEq("rst_edge_outs", 160'({o_cs, o_addr, o_data, o_valid, o_last, o_busy, o_done}), 160'(0));
                @(negedge clk);
                rst = 1'b0;
                finished = 1;
                aborted = 1;
            end
        end
        if (!finished) checkEq("frame_timeout", 160'(0), 160'(1));
        if (!aborted) begin
            @(negedge clk);
            checkEq("done_one_cycle", 160'(o_done), 160'(0));
            checkEq("busy_cleared", 160'(o_busy), 160'(0));
        end
    endtask

    task automatic compareFrame(input int w, input int h, input int p);
        int          pe, rows, cols, idx;
        logic [OW:0] e;
        pe   = (p > 2) ? 2 : p;
        rows = h + 2 * pe;
        cols = w + 2 * pe;
        idx  = 0;
        checkEq("beat_count", 160'(gotQ.size()), 160'(rows * cols));
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                e = '0;
                if (r >= pe && r < h + pe && c >= pe && c < w + pe)
                    for (int k = 0; k < NUM_CH; k++) e[k*PIX_W +: PIX_W] = pix(k, r - pe, c - pe);
                e[OW] = (r == rows - 1) && (c == cols - 1);
                if (idx < gotQ.size()) checkEq($sformatf("beat_%0d", idx), 160'(gotQ[idx]), 160'(e));
                idx++;
            end
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_width = '0; i_height = '0; i_pad = '0; i_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkEq("reset_outs", 160'({o_cs, o_addr, o_data, o_valid, o_last, o_busy, o_done}), 160'(0));
        rst = 1'b0;

        // 4x2 image, pad 1, downstream always ready
        fillBram(4, 2);
        runFrame(4, 2, 1, 0, -1);
        compareFrame(4, 2, 1);
        checkEq("beat7_ch0", 160'(gotQ.size() > 7 ? gotQ[7][7:0] : 8'hFF), 160'(8'h00));
        checkEq("beat7_ch1", 160'(gotQ.size() > 7 ? gotQ[7][15:8] : 8'hFF), 160'(8'h10));
        checkEq("beat10_ch0", 160'(gotQ.size() > 10 ? gotQ[10][7:0] : 8'hFF), 160'(8'h03));
        checkEq("beat23_last", 160'(gotQ.size() > 23 ? gotQ[23] : '0), 160'({1'b1, {OW{1'b0}}}));
        checkEq("first_valid_edges", 160'(firstValidIter - 1), 160'(2));
        checkEq("done_after_last", 160'(doneIter - lastAcceptIter), 160'(1));
        checkEq("done_count", 160'(doneCount), 160'(1));
        checkEq("cs_cycles", 160'(csCount), 160'(8));
        checkEq("cs_all_or_none", 160'(csBad), 160'(0));
`ifdef PARSING_FEEDER_STAT_EN
        checkEq("beat_cnt_run1", 160'(o_beat_cnt), 160'(24));
`endif

        // 20-wide single row, two words per row
        fillBram(20, 1);
        runFrame(20, 1, 0, 0, -1);
        compareFrame(20, 1, 0);
        checkEq("cs_cycles_w20", 160'(csCount), 160'(20));
        checkEq("beat17_addr", 160'(addr17), 160'(1));
        checkEq("beat17_ch2", 160'(gotQ.size() > 17 ? gotQ[17][23:16] : 8'hFF), 160'(8'd49));

        // Same frame as the first, with random backpressure
        fillBram(4, 2);
        runFrame(4, 2, 1, 1, -1);
        compareFrame(4, 2, 1);
        checkEq("done_after_last_bp", 160'(doneIter - lastAcceptIter), 160'(1));

        // Empty frame: W=0
        runFrame(0, 5, 2, 0, -1);
        checkEq("w0_no_beats", 160'(gotQ.size()), 160'(0));
        checkEq("w0_no_valid", 160'(firstValidIter), 160'(-1));
        checkEq("w0_done_iter", 160'(doneIter), 160'(1));
        checkEq("w0_done_count", 160'(doneCount), 160'(1));
        checkEq("w0_busy_cycles", 160'(busyCount), 160'(1));

        // Reset mid-frame, then replay
        runFrame(4, 2, 1, 0, 9);
        checkEq("rst_no_done", 160'(doneCount), 160'(0));
        repeat (4) @(negedge clk);
        checkEq("rst_idle_after", 160'({o_busy, o_done, o_valid}), 160'(0));
        runFrame(4, 2, 1, 0, -1);
        compareFrame(4, 2, 1);
`ifdef PARSING_FEEDER_STAT_EN
        checkEq("beat_cnt_cleared", 160'(cntAtStart), 160'(0));
        checkEq("beat_cnt_run2", 160'(o_beat_cnt), 160'(24));
`endif

        // Pad value 3 clamps to 2 on a 1x1 image
        fillBram(1, 1);
        runFrame(1, 1, 3, 0, -1);
        compareFrame(1, 1, 3);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
